// File: rtl/i2c_bus_ctrl_if.sv
// Open-drain I2C bus shared by the bus controller, the byte transmitter and
// any external device. Each agent owns a drive-low enable per line; a line
// reads 0 when any agent pulls it low and 1 (pulled up) when all release it.
interface i2c_if;
    logic scl_ctrl_oe;  // controller pulls SCL low
    logic sda_ctrl_oe;  // controller pulls SDA low
    logic sda_tx_oe;    // byte transmitter pulls SDA low
    logic scl_dev_oe;   // external device pulls SCL low (clock stretching)
    logic sda_dev_oe;   // external device pulls SDA low (ACK / data)
    logic scl;
    logic sda;

    // Wired-AND resolution with the pull-up modelled as the released level.
    assign scl = ~(scl_ctrl_oe | scl_dev_oe);
    assign sda = ~(sda_ctrl_oe | sda_tx_oe | sda_dev_oe);

    modport ctrl_bus (output scl_ctrl_oe, output sda_ctrl_oe, input scl);
    modport tx_bus   (output sda_tx_oe, input scl, input sda);
    modport dev      (output scl_dev_oe, output sda_dev_oe, input scl, input sda);
endinterface

// File: rtl/i2c_bus_ctrl.sv
// I2C master bus sequencer: generates SCL, START / repeated-START / STOP,
// frames transfers in 9-bit units and hands the SCL phase plus an active-low
// frame request to the downstream byte transmitter.
module i2c_bus_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CLK_DIV  = CLK_FREQ / 100_000,
    parameter int DIV_LEN  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    i2c_if.ctrl_bus            i2c,
    input  logic               start_n,
    input  logic               stop_n,
    input  logic               xfer_n,
    output logic [DIV_LEN-1:0] clk_counter,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    if (CLK_DIV < 8 || (CLK_DIV % 2) != 0 || CLK_FREQ < CLK_DIV) begin : g_bad_div
        $error("i2c_bus_ctrl: CLK_DIV must be even, >= 8 and <= CLK_FREQ");
    end

    localparam logic [DIV_LEN-1:0] CNT_LAST = DIV_LEN'(CLK_DIV - 1);
    localparam logic [DIV_LEN-1:0] CNT_HALF = DIV_LEN'(CLK_DIV / 2);
    localparam logic [DIV_LEN-1:0] CNT_3QTR = DIV_LEN'(3 * CLK_DIV / 4);
    localparam logic [3:0]         LAST_BIT = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CLOCK,
        ST_HOLD,
        ST_RESTART,
        ST_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_LEN-1:0] count_q, count_d;
    logic [3:0]         bit_q, bit_d;
    logic               scl_oe_q, scl_oe_d;
    logic               sda_oe_q, sda_oe_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stretch;
    logic               period_end;
    state_e             cmd_state;

    // Next state, phase counter, bit counter and registered line/status values.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        bit_d    = bit_q;
        done_d   = 1'b0;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;

        // SCL released by us but held low by someone else: freeze the phase.
        stretch    = !scl_oe_q && !i2c.scl;
        period_end = (count_q == CNT_LAST);

        // Boundary command priority: STOP, then (repeated) START, then a byte.
        if (!stop_n)       cmd_state = ST_STOP;
        else if (!start_n) cmd_state = ST_RESTART;
        else if (!xfer_n)  cmd_state = ST_CLOCK;
        else               cmd_state = ST_HOLD;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                bit_d   = '0;
                if (!start_n) state_d = ST_START;
            end
            ST_START, ST_RESTART: begin
                if (!stretch) begin
                    if (period_end) begin
                        state_d = ST_CLOCK;
                        count_d = '0;
                        bit_d   = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_CLOCK: begin
                if (!stretch) begin
                    if (period_end) begin
                        count_d = '0;
                        if (bit_q == LAST_BIT) begin
                            done_d  = 1'b1;
                            bit_d   = '0;
                            state_d = cmd_state;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                count_d = '0;
                bit_d   = '0;
                state_d = cmd_state;
            end
            ST_STOP: begin
                if (!stretch) begin
                    if (period_end) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                bit_d   = '0;
            end
        endcase

        // Line drives are decoded from the upcoming phase so they change on the
        // same edge as the counter; SCL low through the whole first half of a
        // repeated START keeps SDA changes away from a high SCL.
        case (state_d)
            ST_START:   sda_oe_d = (count_d >= CNT_HALF);
            ST_CLOCK:   scl_oe_d = (count_d < CNT_HALF);
            ST_HOLD:    scl_oe_d = 1'b1;
            ST_RESTART: begin
                scl_oe_d = (count_d < CNT_HALF);
                sda_oe_d = (count_d >= CNT_3QTR);
            end
            ST_STOP: begin
                scl_oe_d = (count_d < CNT_HALF);
                sda_oe_d = (count_d < CNT_3QTR);
            end
            default: ;
        endcase

        tx_d   = (state_d != ST_CLOCK);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!rstn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            bit_q    <= '0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            bit_q    <= bit_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign i2c.scl_ctrl_oe = scl_oe_q;
    assign i2c.sda_ctrl_oe = sda_oe_q;
    assign clk_counter     = count_q;
    assign tx              = tx_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_i2c_bus_ctrl.sv
// Directed bench for i2c_bus_ctrl with CLK_DIV = 8: START/STOP, back-to-back
// bytes, hold, clock stretching, repeated START and asynchronous reset.
module tb_i2c_bus_ctrl;
    localparam int CLK_DIV = 8;
    localparam int DIV_LEN = 16;

    logic               clk     = 1'b0;
    logic               rstn    = 1'b0;
    logic               start_n = 1'b1;
    logic               stop_n  = 1'b1;
    logic               xfer_n  = 1'b1;
    logic [DIV_LEN-1:0] clk_counter;
    logic               tx;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    // Frame measurement accumulators.
    int   m_pulses, m_highs, m_tx_hi, m_dones, m_first, m_last, m_idx;
    logic m_prev;

    i2c_if bus ();

    i2c_bus_ctrl #(
        .CLK_FREQ (800_000),
        .CLK_DIV  (CLK_DIV),
        .DIV_LEN  (DIV_LEN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i2c         (bus.ctrl_bus),
        .start_n     (start_n),
        .stop_n      (stop_n),
        .xfer_n      (xfer_n),
        .clk_counter (clk_counter),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_meas();
        m_pulses = 0; m_highs = 0; m_tx_hi = 0; m_dones = 0;
        m_first = -1; m_last = -1; m_idx = 0; m_prev = 1'b0;
    endtask

    // Sample the current negedge, then advance one clock; n times.
    task automatic measure(input int n);
        for (int i = 0; i < n; i++) begin
            if (bus.scl && !m_prev) m_pulses++;
            if (bus.scl) m_highs++;
            if (tx) m_tx_hi++;
            if (done) begin
                if (m_dones == 0) m_first = m_idx;
                m_last = m_idx;
                m_dones++;
            end
            m_prev = bus.scl;
            m_idx++;
            @(negedge clk);
        end
    endtask

    int   k;
    int   frozen;
    int   stop_edges;
    int   busy_low;
    int   activity;
    logic prev_sda, prev_scl;

    initial begin
        bus.scl_dev_oe = 1'b0;
        bus.sda_dev_oe = 1'b0;
        bus.sda_tx_oe  = 1'b0;

        // Reset state.
        adv(2);
        check("rst_counter", 32'(clk_counter), 32'd0);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_scl", 32'(bus.scl), 32'd1);
        check("rst_sda", 32'(bus.sda), 32'd1);
        rstn = 1'b1;
        adv(1);

        // Single START / one frame / STOP.
        start_n = 1'b0;
        adv(1);                                   // E0: kStart entered
        check("start_busy", 32'(busy), 32'd1);
        check("start_cnt0", 32'(clk_counter), 32'd0);
        start_n = 1'b1;
        xfer_n  = 1'b0;
        stop_n  = 1'b0;                           // waits for the frame boundary
        adv(3);                                   // E3
        check("start_sda_hi_before_half", 32'(bus.sda), 32'd1);
        adv(1);                                   // E4
        check("start_sda_fall", 32'(bus.sda), 32'd0);
        check("start_scl_high", 32'(bus.scl), 32'd1);
        adv(4);                                   // E8: kClock
        check("frame_scl_low", 32'(bus.scl), 32'd0);
        check("frame_tx", 32'(tx), 32'd0);
        check("frame_sda_released", 32'(bus.sda), 32'd1);
        clear_meas();
        measure(72);                              // E8..E79, now at E80
        check("frame_pulses", 32'(m_pulses), 32'd9);
        check("frame_high_clocks", 32'(m_highs), 32'd36);
        check("frame_no_early_done", 32'(m_dones), 32'd0);
        check("frame_done", 32'(done), 32'd1);
        check("stop_tx", 32'(tx), 32'd1);
        check("stop_sda_low", 32'(bus.sda), 32'd0);
        stop_n = 1'b1;
        xfer_n = 1'b1;
        adv(4);                                   // E84
        check("stop_scl_high", 32'(bus.scl), 32'd1);
        check("stop_sda_still_low", 32'(bus.sda), 32'd0);
        adv(2);                                   // E86
        check("stop_sda_rise", 32'(bus.sda), 32'd1);
        check("stop_scl_high_at_rise", 32'(bus.scl), 32'd1);
        adv(1);                                   // E87
        check("stop_busy_e87", 32'(busy), 32'd1);
        adv(1);                                   // E88
        check("stop_busy_e88", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd1);

        // Back-to-back bytes, then hold.
        start_n = 1'b0;
        xfer_n  = 1'b0;
        adv(1);                                   // F0
        start_n = 1'b1;
        adv(8);                                   // F8
        clear_meas();
        measure(180);                             // F8..F187
        xfer_n = 1'b1;                            // mid third frame
        measure(36);                              // F188..F223, now at F224
        check("b2b_pulses", 32'(m_pulses), 32'd27);
        check("b2b_high_clocks", 32'(m_highs), 32'd108);
        check("b2b_tx_gaps", 32'(m_tx_hi), 32'd0);
        check("b2b_done_count", 32'(m_dones), 32'd2);
        check("b2b_first_done", 32'(m_first), 32'd72);
        check("b2b_done_spacing", 32'(m_last - m_first), 32'd72);
        check("b2b_third_done", 32'(done), 32'd1);
        check("hold_scl", 32'(bus.scl), 32'd0);
        check("hold_tx", 32'(tx), 32'd1);
        check("hold_cnt", 32'(clk_counter), 32'd0);
        adv(5);
        check("hold_scl_later", 32'(bus.scl), 32'd0);
        check("hold_cnt_later", 32'(clk_counter), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        xfer_n = 1'b0;
        adv(1);                                   // G0
        check("resume_tx", 32'(tx), 32'd0);
        xfer_n = 1'b1;
        adv(1);                                   // G1
        check("resume_cnt", 32'(clk_counter), 32'd1);

        // Clock stretching during bit 3.
        adv(27);                                  // G28: bit 3, count 4
        check("stretch_cnt_g28", 32'(clk_counter), 32'd4);
        bus.scl_dev_oe = 1'b1;
        frozen = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            if (clk_counter == 16'd4 && !bus.scl) frozen++;
        end
        check("stretch_frozen", 32'(frozen), 32'd20);
        bus.scl_dev_oe = 1'b0;
        start_n = 1'b0;                           // repeated START at the boundary
        adv(1);                                   // G49
        check("stretch_resume", 32'(clk_counter), 32'd5);
        k = 49;
        while (!done && k < 200) begin
            adv(1);
            k++;
        end
        check("stretch_frame_len", 32'(k), 32'd92);

        // Repeated START.
        check("rs_busy", 32'(busy), 32'd1);
        check("rs_scl_low", 32'(bus.scl), 32'd0);
        check("rs_sda_released", 32'(bus.sda), 32'd1);
        start_n = 1'b1;
        stop_edges = 0;
        busy_low   = 0;
        prev_sda   = bus.sda;
        prev_scl   = bus.scl;
        for (int i = 0; i < 8; i++) begin
            if (bus.sda && !prev_sda && bus.scl && prev_scl) stop_edges++;
            if (!busy) busy_low++;
            if (i == 5) check("rs_sda_high_c5", 32'({bus.scl, bus.sda}), 32'd3);
            if (i == 6) check("rs_sda_fall_c6", 32'({bus.scl, bus.sda}), 32'd2);
            prev_sda = bus.sda;
            prev_scl = bus.scl;
            adv(1);
        end                                       // now at G100
        check("rs_no_stop", 32'(stop_edges), 32'd0);
        check("rs_busy_kept", 32'(busy_low), 32'd0);
        check("rs_clock_tx", 32'(tx), 32'd0);
        check("rs_clock_cnt", 32'(clk_counter), 32'd0);

        // Asynchronous reset during bit 5.
        adv(42);                                  // bit 5, count 2, SCL low
        check("pre_reset_scl", 32'(bus.scl), 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("arst_scl", 32'(bus.scl), 32'd1);
        check("arst_sda", 32'(bus.sda), 32'd1);
        check("arst_outputs", 32'({clk_counter, tx, busy, done}), 32'({16'd0, 1'b1, 1'b0, 1'b0}));
        adv(2);
        rstn = 1'b1;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            if (!bus.scl || !bus.sda || busy || !tx || done || clk_counter != '0) activity++;
        end
        check("arst_quiet", 32'(activity), 32'd0);
        start_n = 1'b0;
        adv(1);
        check("restart_busy", 32'(busy), 32'd1);
        start_n = 1'b1;
        adv(4);
        check("restart_sda_fall", 32'({bus.scl, bus.sda}), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
